reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_scoreboard.sv | 74 +++++++
 rtl/reg_file_sb.sv | 101 ++++++++++
 tb/tb_reg_file_sb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Purpose  : Shared defaults for the register file / scoreboard slice and the
//            helper that derives the register address width from the count.
// Revision : 1.0  initial release
// ============================================================================
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Address width for a given register count (count is a power of two).
  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

  localparam int AW_DEF = addr_width(NREGS_DEF);

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : One pending bit per architectural register plus a registered
//            count of pending registers.  Issue marks a destination pending,
//            writeback clears it, flush clears everything.
// Ports    : Clock      in   rising-edge clock
//            nReset     in   asynchronous active-low reset
//            issueEn    in   instruction issued with a destination
//            issueRd    in   destination to mark pending
//            writeEn    in   writeback strobe (clears wrAddr)
//            wrAddr     in   writeback destination
//            flush      in   clear all pending marks
//            pending    out  pending bit vector
//            pendCount  out  number of set pending bits
// Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             issueEn,
  input  logic [AW-1:0]    issueRd,
  input  logic             writeEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic             flush,
  output logic [NREGS-1:0] pending,
  output logic [AW:0]      pendCount
);

  logic             set_ok;
  logic             inc;
  logic             dec;
  logic [NREGS-1:0] pending_next;
  logic [AW:0]      count_next;

  always_comb begin
    // Register 0 is never a real producer target when it is hardwired zero.
    set_ok = issueEn && !((ZERO_REG != 0) && (issueRd == '0));
    // Count goes up only when a clear bit becomes set; it goes down only when
    // a set bit is cleared and no issue to the same register re-sets it.
    inc    = set_ok && !pending[issueRd];
    dec    = writeEn && pending[wrAddr] && !(set_ok && (issueRd == wrAddr));

    pending_next = pending;
    count_next   = pendCount + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};

    if (flush) begin
      pending_next = '0;
      count_next   = '0;
    end else begin
      // Clear before set so a same-cycle issue (new producer) wins.
      if (writeEn) pending_next[wrAddr]  = 1'b0;
      if (set_ok)  pending_next[issueRd] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pending   <= '0;
      pendCount <= '0;
    end else begin
      pending   <= pending_next;
      pendCount <= count_next;
    end
  end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Multi-read-port register file with same-cycle write bypass and
//            an attached scoreboard that reports per-port operand hazards.
// Ports    : Clock      in   rising-edge clock
//            nReset     in   asynchronous active-low reset
//            writeEn    in   writeback strobe
//            wrAddr     in   writeback destination
//            wrData     in   writeback data
//            rdAddr     in   packed per-port read addresses (port i at i*AW)
//            rdValid    in   per-port operand needed this cycle
//            rdData     out  packed per-port read data (port i at i*XLEN)
//            rdBusy     out  per-port operand pending
//            stall      out  any needed operand is pending
//            issueEn    in   instruction issued with destination
//            issueRd    in   destination marked pending
//            flush      in   clear all pending marks
//            pendCount  out  number of pending registers
// Revision : 1.0  initial release
// ============================================================================
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                writeEn,
  input  logic [AW-1:0]       wrAddr,
  input  logic [XLEN-1:0]     wrData,
  input  logic [NRD*AW-1:0]   rdAddr,
  input  logic [NRD-1:0]      rdValid,
  output logic [NRD*XLEN-1:0] rdData,
  output logic [NRD-1:0]      rdBusy,
  output logic                stall,
  input  logic                issueEn,
  input  logic [AW-1:0]       issueRd,
  input  logic                flush,
  output logic [AW:0]         pendCount
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] pending;
  logic             wr_ok;

  // Writes to register 0 are dropped (and never bypassed) when it is hardwired.
  assign wr_ok = writeEn && !((ZERO_REG != 0) && (wrAddr == '0));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int k = 0; k < NREGS; k++) mem[k] <= '0;
    end else if (wr_ok) begin
      mem[wrAddr] <= wrData;
    end
  end

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;

      assign addr = rdAddr[i*AW +: AW];
      assign hit  = writeEn && (wrAddr == addr);

      always_comb begin
        rdData[i*XLEN +: XLEN] = mem[addr];
        if (wr_ok && hit)
          rdData[i*XLEN +: XLEN] = wrData;
        else if ((ZERO_REG != 0) && (addr == '0))
          rdData[i*XLEN +: XLEN] = '0;
      end

      // A writeback landing this cycle resolves the hazard immediately.
      assign rdBusy[i] = pending[addr] && !hit;
    end : g_rd
  endgenerate

  assign stall = |(rdValid & rdBusy);

  reg_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .Clock     (Clock),
    .nReset    (nReset),
    .issueEn   (issueEn),
    .issueRd   (issueRd),
    .writeEn   (writeEn),
    .wrAddr    (wrAddr),
    .flush     (flush),
    .pending   (pending),
    .pendCount (pendCount)
  );

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Purpose  : Directed self-checking bench for reg_file_sb (default params).
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  logic                Clock;
  logic                nReset;
  logic                writeEn;
  logic [AW-1:0]       wrAddr;
  logic [XLEN-1:0]     wrData;
  logic [NRD*AW-1:0]   rdAddr;
  logic [NRD-1:0]      rdValid;
  logic [NRD*XLEN-1:0] rdData;
  logic [NRD-1:0]      rdBusy;
  logic                stall;
  logic                issueEn;
  logic [AW-1:0]       issueRd;
  logic                flush;
  logic [AW:0]         pendCount;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (1)
  ) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .writeEn   (writeEn),
    .wrAddr    (wrAddr),
    .wrData    (wrData),
    .rdAddr    (rdAddr),
    .rdValid   (rdValid),
    .rdData    (rdData),
    .rdBusy    (rdBusy),
    .stall     (stall),
    .issueEn   (issueEn),
    .issueRd   (issueRd),
    .flush     (flush),
    .pendCount (pendCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_rd(input int port, input int addr);
    rdAddr[port*AW +: AW] = addr[AW-1:0];
  endtask

  function automatic logic [XLEN-1:0] rd(input int port);
    return rdData[port*XLEN +: XLEN];
  endfunction

  task automatic idle();
    writeEn = 1'b0; wrAddr = '0; wrData = '0;
    issueEn = 1'b0; issueRd = '0; flush = 1'b0;
  endtask

  initial begin
    nReset = 1'b0;
    rdAddr = '0; rdValid = '0;
    idle();

    // Reset state
    #2;
    set_rd(0, 5); set_rd(1, 7); rdValid = 2'b11;
    #1;
    check("rst_pend",  pendCount, 0);
    check("rst_rd0",   rd(0), 0);
    check("rst_busy",  rdBusy, 0);
    check("rst_stall", stall, 0);
    rdValid = '0;
    #9 nReset = 1'b1;  // release at t=12, away from edges
    tick();

    // Write x5, same-cycle bypass then registered read
    writeEn = 1; wrAddr = 5; wrData = 32'hDEADBEEF;
    set_rd(0, 5); set_rd(1, 6);
    #1;
    check("byp_x5",    rd(0), 32'hDEADBEEF);
    check("byp_other", rd(1), 0);
    tick();
    idle();
    #1;
    check("rd_x5", rd(0), 32'hDEADBEEF);

    // x0 hardwired zero
    writeEn = 1; wrAddr = 0; wrData = 32'h1234; set_rd(0, 0);
    #1;
    check("x0_nobyp", rd(0), 0);
    tick();
    idle();
    #1;
    check("x0_rd", rd(0), 0);
    issueEn = 1; issueRd = 0;
    tick();
    idle();
    check("x0_issue_pend", pendCount, 0);

    // Issue x7, hazard on port 1, resolved by same-cycle writeback
    issueEn = 1; issueRd = 7;
    tick();
    idle();
    set_rd(0, 5); set_rd(1, 7); rdValid = 2'b10;
    #1;
    check("x7_busy",  rdBusy, 2'b10);
    check("x7_stall", stall, 1);
    check("x7_pend",  pendCount, 1);
    writeEn = 1; wrAddr = 7; wrData = 32'h77;
    #1;
    check("x7_wb_busy",  rdBusy, 2'b00);
    check("x7_wb_stall", stall, 0);
    check("x7_wb_data",  rd(1), 32'h77);
    tick();
    idle();
    check("x7_wb_pend", pendCount, 0);
    rdValid = '0;

    // Issue + writeback same register while pending
    issueEn = 1; issueRd = 3;
    tick();
    check("x3_pend1", pendCount, 1);
    issueEn = 1; issueRd = 3; writeEn = 1; wrAddr = 3; wrData = 32'h33;
    tick();
    idle();
    set_rd(0, 3);
    #1;
    check("x3_still_pend", pendCount, 1);
    check("x3_busy",       rdBusy[0], 1);
    check("x3_data",       rd(0), 32'h33);
    // Re-issue an already pending register
    issueEn = 1; issueRd = 3;
    tick();
    check("x3_reissue", pendCount, 1);
    // Writeback to a non-pending register
    issueEn = 0; writeEn = 1; wrAddr = 10; wrData = 32'hA0A0;
    tick();
    idle();
    set_rd(1, 10);
    #1;
    check("x10_nopend", pendCount, 1);
    check("x10_data",   rd(1), 32'hA0A0);
    writeEn = 1; wrAddr = 3; wrData = 32'h333;
    tick();
    idle();
    check("x3_clear", pendCount, 0);

    // Three issues then flush with a concurrent issue
    for (int r = 1; r <= 3; r++) begin
      issueEn = 1; issueRd = r[AW-1:0];
      tick();
    end
    idle();
    check("pend3", pendCount, 3);
    flush = 1; issueEn = 1; issueRd = 4;
    tick();
    idle();
    set_rd(0, 4); rdValid = 2'b01;
    #1;
    check("flush_pend",  pendCount, 0);
    check("flush_x4",    rdBusy[0], 0);
    check("flush_stall", stall, 0);
    rdValid = '0;

    // Flush still performs the data write
    issueEn = 1; issueRd = 12;
    tick();
    flush = 1; issueEn = 1; issueRd = 13; writeEn = 1; wrAddr = 12; wrData = 32'hABC;
    tick();
    idle();
    set_rd(0, 12); set_rd(1, 13);
    #1;
    check("flushwr_pend", pendCount, 0);
    check("flushwr_data", rd(0), 32'hABC);
    check("flushwr_busy", rdBusy, 0);

    // Reset asserted mid-write
    issueEn = 1; issueRd = 8;
    tick();
    check("pre_rst_pend", pendCount, 1);
    issueEn = 1; issueRd = 9; writeEn = 1; wrAddr = 9; wrData = 32'hFF;
    #2 nReset = 1'b0;
    #1;
    check("in_rst_pend", pendCount, 0);
    @(posedge Clock);
    #2;
    idle();
    #2 nReset = 1'b1;
    tick();
    set_rd(0, 9); set_rd(1, 5);
    #1;
    check("rst_x9",   rd(0), 0);
    check("rst_x5",   rd(1), 0);
    check("rst_pend2", pendCount, 0);
    check("rst_busy2", rdBusy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_sb
`default_nettype wire
